// File: rtl/amp_cfg_sequencer.sv
`timescale 1ns/1ps
// Amplifier power-up and I2C configuration sequencer: power, trigger the master, watch the bus to idle.
// Latency: trigger after PWRUP_CYC+SETTLE_CYC; DONE IDLE_CYC cycles after the final STOP; ERR TIMEOUT_CYC after trigger.
// Backpressure: none; start_req is honoured only in DONE/ERR and dropped elsewhere (no queuing).
module amp_cfg_sequencer #(
    parameter int PWRUP_CYC   = 1000,
    parameter int SETTLE_CYC  = 200,
    parameter int TRIG_CYC    = 16,
    parameter int IDLE_CYC    = 400,
    parameter int TIMEOUT_CYC = 60000,
    parameter int CNT_W       = 16
) (
    input  logic clk_in,
    input  logic resetb,
    input  logic start_req,
    input  logic bus_scl,
    input  logic bus_sda,
    output logic if_resetb,
    output logic send_cfg,
    output logic amp_en,
    output logic amp_mute,
    output logic cfg_busy,
    output logic cfg_done,
    output logic cfg_err
);

    typedef enum logic [2:0] {
        ST_PWR_WAIT   = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_TRIGGER    = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_IDLE  = 3'd4,
        ST_DONE       = 3'd5,
        ST_ERR        = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] C_ZERO      = '0;
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_PWRUP_M1  = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] C_SETTLE_M1 = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] C_TRIG_M1   = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] C_IDLE_M1   = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] C_TO        = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] C_TO_M1     = CNT_W'(TIMEOUT_CYC - 1);

    state_t           r_state;
    state_t           w_nxt_state;
    logic [CNT_W-1:0] r_phase_cnt;
    logic [CNT_W-1:0] w_phase_ld;
    logic [CNT_W-1:0] r_to_cnt;
    logic [CNT_W-1:0] r_idle_cnt;
    logic             r_scl_q;
    logic             r_sda_q;
    logic             r_scl_p;
    logic             r_sda_p;
    logic             r_stop_seen;
    logic             w_start;
    logic             w_stop;
    logic             w_enter_trig;
    logic             w_enter_idle;
    logic             w_to_hit;
    logic             w_bus_idle;
    logic             w_if_resetb;
    logic             w_send_cfg;
    logic             w_amp_en;
    logic             w_amp_mute;
    logic             w_busy;
    logic             w_done;
    logic             w_err;

    // START/STOP need SCL high in both the current and previous sample.
    assign w_start      = r_scl_p & r_scl_q & r_sda_p & ~r_sda_q;
    assign w_stop       = r_scl_p & r_scl_q & ~r_sda_p & r_sda_q;
    assign w_bus_idle   = r_scl_q & r_sda_q;
    assign w_enter_trig = (w_nxt_state == ST_TRIGGER) && (r_state != ST_TRIGGER);
    assign w_enter_idle = (w_nxt_state == ST_WAIT_IDLE) && (r_state != ST_WAIT_IDLE);
    // Compare against TIMEOUT-1 so ERR lands exactly TIMEOUT_CYC cycles after trigger entry,
    // on the same edge the counter reaches TIMEOUT_CYC.
    assign w_to_hit     = (r_to_cnt >= C_TO_M1);

    // Bus sample pipeline: current and previous SCL/SDA, idle-high after reset.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            r_scl_q <= 1'b1;
            r_sda_q <= 1'b1;
            r_scl_p <= 1'b1;
            r_sda_p <= 1'b1;
        end else begin
            r_scl_q <= bus_scl;
            r_sda_q <= bus_sda;
            r_scl_p <= r_scl_q;
            r_sda_p <= r_sda_q;
        end
    end

    // Transaction tracking: last event was STOP, and length of the current all-high run.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            r_stop_seen <= 1'b0;
            r_idle_cnt  <= C_ZERO;
        end else begin
            if (w_enter_trig) begin
                r_stop_seen <= 1'b0;
            end else if (w_stop) begin
                r_stop_seen <= 1'b1;
            end else if (w_start) begin
                r_stop_seen <= 1'b0;
            end

            // Saturates at IDLE_CYC-1 so a long idle stretch never wraps back to zero.
            if (w_enter_trig || w_enter_idle || !w_bus_idle) begin
                r_idle_cnt <= C_ZERO;
            end else if (r_idle_cnt != C_IDLE_M1) begin
                r_idle_cnt <= r_idle_cnt + C_ONE;
            end
        end
    end

    // Phase counter reloads on every state change; timeout counter restarts at trigger and saturates.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            r_phase_cnt <= C_PWRUP_M1;
            r_to_cnt    <= C_ZERO;
        end else begin
            if (w_nxt_state != r_state) begin
                r_phase_cnt <= w_phase_ld;
            end else if (r_phase_cnt != C_ZERO) begin
                r_phase_cnt <= r_phase_cnt - C_ONE;
            end

            if (w_enter_trig) begin
                r_to_cnt <= C_ZERO;
            end else if (r_to_cnt != C_TO) begin
                r_to_cnt <= r_to_cnt + C_ONE;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_PWR_WAIT;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state logic plus output decode of the next state, so outputs register in step with the state.
    always_comb begin
        w_nxt_state = r_state;
        w_phase_ld  = C_ZERO;
        w_if_resetb = 1'b0;
        w_send_cfg  = 1'b0;
        w_amp_en    = 1'b1;
        w_amp_mute  = 1'b1;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            ST_PWR_WAIT: begin
                if (r_phase_cnt == C_ZERO) w_nxt_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_phase_cnt == C_ZERO) w_nxt_state = ST_TRIGGER;
            end
            ST_TRIGGER: begin
                if (r_phase_cnt == C_ZERO) w_nxt_state = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (w_to_hit) begin
                    w_nxt_state = ST_ERR;
                end else if (w_start) begin
                    w_nxt_state = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_to_hit) begin
                    w_nxt_state = ST_ERR;
                end else if (r_stop_seen && (r_idle_cnt == C_IDLE_M1)) begin
                    w_nxt_state = ST_DONE;
                end
            end
            ST_DONE, ST_ERR: begin
                // Re-entering SETTLE holds the master in reset so it will accept a fresh trigger.
                if (start_req) w_nxt_state = ST_SETTLE;
            end
            default: begin
                w_nxt_state = ST_PWR_WAIT;
            end
        endcase

        case (w_nxt_state)
            ST_PWR_WAIT: begin
                w_phase_ld = C_PWRUP_M1;
                w_amp_en   = 1'b0;
            end
            ST_SETTLE: begin
                w_phase_ld = C_SETTLE_M1;
            end
            ST_TRIGGER: begin
                w_phase_ld  = C_TRIG_M1;
                w_if_resetb = 1'b1;
                w_send_cfg  = 1'b1;
            end
            ST_WAIT_START, ST_WAIT_IDLE: begin
                w_if_resetb = 1'b1;
            end
            ST_DONE: begin
                w_if_resetb = 1'b1;
                w_amp_mute  = 1'b0;
                w_busy      = 1'b0;
                w_done      = 1'b1;
            end
            ST_ERR: begin
                w_if_resetb = 1'b1;
                w_busy      = 1'b0;
                w_err       = 1'b1;
            end
            default: begin
                w_amp_en = 1'b0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            if_resetb <= 1'b0;
            send_cfg  <= 1'b0;
            amp_en    <= 1'b0;
            amp_mute  <= 1'b1;
            cfg_busy  <= 1'b1;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            if_resetb <= w_if_resetb;
            send_cfg  <= w_send_cfg;
            amp_en    <= w_amp_en;
            amp_mute  <= w_amp_mute;
            cfg_busy  <= w_busy;
            cfg_done  <= w_done;
            cfg_err   <= w_err;
        end
    end

endmodule

// File: tb/tb_amp_cfg_sequencer.sv
`timescale 1ns/1ps
// Bench for amp_cfg_sequencer: generated I2C-like bus waveforms against a waveform-scanning reference.
// Outputs compared every cycle, plus event timings (enable, trigger, width, DONE/ERR time).
// No backpressure on the DUT; start_req pulses are placed at chosen cycles.
module tb_amp_cfg_sequencer;

    localparam int P_PWR  = 10;
    localparam int P_SET  = 5;
    localparam int P_TRIG = 4;
    localparam int P_IDLE = 8;
    localparam int P_TO   = 300;
    localparam int MAXT   = 4096;

    // {if_resetb, send_cfg, amp_en, amp_mute, cfg_busy, cfg_done, cfg_err}
    localparam logic [6:0] V_PWR  = 7'b0001100;
    localparam logic [6:0] V_SET  = 7'b0011100;
    localparam logic [6:0] V_TRIG = 7'b1111100;
    localparam logic [6:0] V_WAIT = 7'b1011100;
    localparam logic [6:0] V_DONE = 7'b1010010;
    localparam logic [6:0] V_ERR  = 7'b1011001;

    localparam int K_NOM   = 0;
    localparam int K_IDLE  = 1;
    localparam int K_TWO   = 2;
    localparam int K_STUCK = 3;
    localparam int K_RAND  = 4;

    logic clk_in    = 1'b0;
    logic resetb    = 1'b0;
    logic start_req = 1'b0;
    logic bus_scl   = 1'b1;
    logic bus_sda   = 1'b1;
    logic if_resetb, send_cfg, amp_en, amp_mute, cfg_busy, cfg_done, cfg_err;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] bw [MAXT];   // {scl, sda} sampled at edge index
    int t;
    int wp;
    int g_ss, g_t0, g_d, g_req_t, g_last_stop;
    bit g_ok;
    logic [6:0] g_pre;
    int m_en_t, m_trig_t, m_send_n, m_end_t;
    logic [6:0] m_prev;

    amp_cfg_sequencer #(
        .PWRUP_CYC(P_PWR), .SETTLE_CYC(P_SET), .TRIG_CYC(P_TRIG),
        .IDLE_CYC(P_IDLE), .TIMEOUT_CYC(P_TO), .CNT_W(16)
    ) dut (
        .clk_in(clk_in), .resetb(resetb), .start_req(start_req),
        .bus_scl(bus_scl), .bus_sda(bus_sda),
        .if_resetb(if_resetb), .send_cfg(send_cfg), .amp_en(amp_en), .amp_mute(amp_mute),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500_000;
        $display("FAIL watchdog t=%0d got=hang exp=finish", t);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=0x%0h exp=0x%0h", tag, t, got, exp);
        end
    endtask

    function automatic logic [6:0] obs();
        return {if_resetb, send_cfg, amp_en, amp_mute, cfg_busy, cfg_done, cfg_err};
    endfunction

    function automatic bit is_start(input int e);
        return (bw[e-1] == 2'b11) && (bw[e] == 2'b10);
    endfunction

    function automatic bit is_stop(input int e);
        return (bw[e-1] == 2'b10) && (bw[e] == 2'b11);
    endfunction

    // Reference: scan the waveform. Sequencer listens from trigger end; first START opens the
    // transaction window; DONE once the latest event is a STOP and IDLE_CYC consecutive idle
    // samples have been seen; ERR at exactly trigger+TIMEOUT if neither finishes first.
    function automatic void predict(input int t0, output int d, output bit ok);
        int lim;
        int es;
        bit stop_seen;
        int run;
        lim = t0 + P_TO;
        es = -1;
        stop_seen = 1'b0;
        run = 0;
        d = lim;
        ok = 1'b0;
        for (int e = t0 + P_TRIG; e <= lim - 2; e++) begin
            if (is_start(e)) begin
                es = e;
                break;
            end
        end
        if (es < 0) return;
        for (int x = es + 1; x <= lim - 2; x++) begin
            if (is_stop(x - 1)) stop_seen = 1'b1;
            else if (is_start(x - 1)) stop_seen = 1'b0;
            run = (bw[x-1] == 2'b11) ? run + 1 : 0;
            if (stop_seen && run >= P_IDLE - 1) begin
                d = x + 1;
                ok = 1'b1;
                return;
            end
        end
    endfunction

    function automatic logic [6:0] exp_vec(input int tt);
        if (tt < g_ss) return g_pre;
        if (tt < g_t0) return V_SET;
        if (tt < g_t0 + P_TRIG) return V_TRIG;
        if (tt < g_d) return V_WAIT;
        return g_ok ? V_DONE : V_ERR;
    endfunction

    task automatic wave_clear(input int from);
        for (int i = from; i < MAXT; i++) bw[i] = 2'b11;
    endtask

    task automatic put(input logic [1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            if (wp < MAXT) begin
                bw[wp] = v;
                wp++;
            end
        end
    endtask

    // START, n data bits (SDA changes only while SCL low), then STOP.
    task automatic put_txn(input int nbits);
        logic d;
        put(2'b10, 2);
        for (int i = 0; i < nbits; i++) begin
            d = 1'($urandom_range(0, 1));
            put({1'b0, d}, 2);
            put({1'b1, d}, 2);
        end
        put(2'b00, 2);
        put(2'b10, 2);
        g_last_stop = wp;
        put(2'b11, 1);
    endtask

    task automatic build(input int kind);
        int base;
        int n;
        base = g_t0 + P_TRIG;
        wave_clear(g_ss);
        g_last_stop = -1;
        case (kind)
            K_NOM: begin
                wp = base + 3;
                put_txn(9);
            end
            K_IDLE: begin
                wp = base;
            end
            K_TWO: begin
                wp = base + 3;
                put_txn(4);
                put(2'b11, 4);   // five idle samples including the STOP sample
                put_txn(3);
            end
            K_STUCK: begin
                wp = base + 3;
                put(2'b10, MAXT);
            end
            default: begin
                wp = g_t0 + 1 + $urandom_range(0, 6);   // may begin while still triggering
                if ($urandom_range(0, 9) == 0) wp += P_TO;
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) begin
                    put_txn($urandom_range(1, 6));
                    put(2'b11, $urandom_range(0, P_IDLE + 2));
                end
                if ($urandom_range(0, 4) == 0) begin
                    put(2'b11, 1);
                    put(2'b10, MAXT);
                end
            end
        endcase
        predict(g_t0, g_d, g_ok);
    endtask

    task automatic clr_meas();
        m_en_t = -1;
        m_trig_t = -1;
        m_send_n = 0;
        m_end_t = -1;
        m_prev = obs();
    endtask

    task automatic run_to(input int tend);
        logic [6:0] o;
        while (t < tend) begin
            {bus_scl, bus_sda} = bw[t+1];
            start_req = (t + 1 == g_req_t);
            @(posedge clk_in);
            #1;
            t++;
            o = obs();
            chk("outputs", int'(o), int'(exp_vec(t)));
            if (!m_prev[4] && o[4] && m_en_t < 0) m_en_t = t;
            if (!m_prev[5] && o[5] && m_trig_t < 0) m_trig_t = t;
            if (o[5]) m_send_n++;
            if ((o[1] || o[0]) && m_end_t < 0) m_end_t = t;
            m_prev = o;
        end
        start_req = 1'b0;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        start_req = 1'b0;
        g_req_t = -1;
        bus_scl = 1'b1;
        bus_sda = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        t = 0;
        chk("reset_state", int'(obs()), int'(V_PWR));
        @(negedge clk_in);
        resetb = 1'b1;
    endtask

    task automatic begin_pwr();
        g_ss = P_PWR;
        g_t0 = P_PWR + P_SET;
        g_pre = V_PWR;
        clr_meas();
    endtask

    task automatic end_checks(input bit pwr);
        if (pwr) chk("en_rise", m_en_t, P_PWR);
        chk("trig_rise", m_trig_t, g_t0);
        chk("send_width", m_send_n, P_TRIG);
        chk("end_time", m_end_t, g_d);
        chk("outcome", int'({cfg_done, cfg_err}), g_ok ? 2 : 1);
    endtask

    initial begin
        wave_clear(0);
        t = 0;

        // Nominal power-up with an ignored start_req in the transaction window.
        do_reset();
        begin_pwr();
        build(K_NOM);
        g_req_t = g_t0 + P_TRIG + 8;
        run_to(g_d + 2);
        end_checks(1'b1);
        chk("stop_to_done", m_end_t - g_last_stop, P_IDLE);

        // start_req in DONE re-runs the sequence from SETTLE.
        g_ss = t + 1;
        g_t0 = g_ss + P_SET;
        g_pre = V_DONE;
        g_req_t = g_ss;
        clr_meas();
        build(K_NOM);
        run_to(g_d + 2);
        end_checks(1'b0);
        chk("restart_done", m_end_t - g_last_stop, P_IDLE);

        // Bus idle after trigger: ERR exactly TIMEOUT cycles after trigger.
        do_reset();
        begin_pwr();
        build(K_IDLE);
        run_to(g_d + 2);
        end_checks(1'b1);
        chk("idle_timeout", m_end_t - m_trig_t, P_TO);

        // Two transactions with a short gap: DONE only after the second STOP.
        do_reset();
        begin_pwr();
        build(K_TWO);
        run_to(g_d + 2);
        end_checks(1'b1);
        chk("two_txn_done", m_end_t - g_last_stop, P_IDLE);

        // SDA stuck low after START.
        do_reset();
        begin_pwr();
        build(K_STUCK);
        run_to(g_d + 2);
        end_checks(1'b1);
        chk("stuck_timeout", m_end_t - m_trig_t, P_TO);

        // Asynchronous reset in the middle of a transaction, then a full restart.
        do_reset();
        begin_pwr();
        build(K_NOM);
        run_to(g_t0 + P_TRIG + 10);
        #3 resetb = 1'b0;
        #1 chk("async_reset", int'(obs()), int'(V_PWR));
        do_reset();
        begin_pwr();
        build(K_NOM);
        run_to(g_d + 2);
        end_checks(1'b1);

        // Randomized bus traffic.
        for (int k = 0; k < 30; k++) begin
            do_reset();
            begin_pwr();
            build(K_RAND);
            run_to(g_d + 2);
            end_checks(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/amp_cfg_sequencer.md
Name: amp_cfg_sequencer

Overview:
Power-up and configuration sequencer that sits directly upstream of the amplifier I2C master. After reset it holds the amplifier powered down and muted, then enables it and waits for supply settling. It then releases the I2C master from reset and pulses its send_cfg trigger, monitors the resulting SCL/SDA traffic until the bus returns to idle, and unmutes the amplifier on success or flags an error on timeout.

Parameters:
PWRUP_CYC, 1000, clk_in cycles with amp_en low after reset release (>=1)
SETTLE_CYC, 200, clk_in cycles between amp_en rising and I2C master reset release (>=1)
TRIG_CYC, 16, send_cfg high width in clk_in cycles; must be >= 2*DIV of the master clock divider (>=1)
IDLE_CYC, 400, consecutive clk_in cycles with SCL=SDA=1 after the last stop that declare configuration complete (>=1)
TIMEOUT_CYC, 60000, maximum clk_in cycles from send_cfg rising to DONE before ERR (must exceed IDLE_CYC)
CNT_W, 16, width of the phase and timeout counters; all *_CYC values must fit

Ports:
clk_in  in  1  system clock; same clock that feeds the I2C master
resetb  in  1  asynchronous active-low reset
start_req  in  1  single-cycle request to reconfigure; honoured only in DONE or ERR
bus_scl  in  1  observed SCL from the I2C master
bus_sda  in  1  observed SDA from the I2C master
if_resetb  out  1  active-low reset to the I2C master
send_cfg  out  1  configuration trigger to the I2C master
amp_en  out  1  amplifier enable (power-down release)
amp_mute  out  1  amplifier mute, 1 = muted
cfg_busy  out  1  high in every state except DONE and ERR
cfg_done  out  1  high in DONE
cfg_err  out  1  high in ERR

Behaviour:
- Reset (async assert, sync-free release): state=PWR_WAIT, counter=PWRUP_CYC-1, amp_en=0, amp_mute=1, if_resetb=0, send_cfg=0, cfg_busy=1, cfg_done=0, cfg_err=0, timeout counter=0. Bus sample flops are set to 1.
- All outputs are registered; no combinational paths from inputs to outputs.
- Bus monitor: bus_scl and bus_sda are registered once (scl_q, sda_q) and compared with the previous samples. START = scl high in both samples and sda 1->0. STOP = scl high in both samples and sda 0->1. Monitor state is cleared on entry to TRIGGER.
- Phase counter: loaded with N-1 on state entry and decremented each cycle. The transition happens on the cycle the counter reads 0, so a state occupies exactly N cycles.
- PWR_WAIT (PWRUP_CYC cycles): amp_en=0, if_resetb=0, then go to SETTLE.
- SETTLE (SETTLE_CYC cycles): amp_en=1, amp_mute=1, if_resetb=0, then go to TRIGGER.
- TRIGGER (TRIG_CYC cycles): if_resetb=1 and send_cfg=1, starting on the first TRIGGER cycle. The timeout counter clears here, then go to WAIT_START with send_cfg=0.
- WAIT_START: wait for START. On START go to WAIT_IDLE with the idle counter at 0. If STOP or START has not occurred and the timeout counter reaches TIMEOUT_CYC, go to ERR.
- WAIT_IDLE: a stop_seen flag is set on STOP and cleared on START (repeated transactions are allowed). The idle counter increments while scl_q=sda_q=1 and resets to 0 on any low sample. When stop_seen=1 and the idle counter reaches IDLE_CYC-1, go to DONE. A timeout counter reaching TIMEOUT_CYC has priority and goes to ERR.
- DONE: amp_mute=0, cfg_done=1, cfg_busy=0. if_resetb stays 1.
- ERR: amp_mute=1, cfg_err=1, cfg_busy=0. amp_en stays 1.
- The timeout counter runs from the TRIGGER entry, saturates at TIMEOUT_CYC and never wraps.
- start_req in DONE or ERR: next state is SETTLE with amp_mute=1, if_resetb=0, cfg_done=0, cfg_err=0 and amp_en unchanged. This resets the master before retriggering, because the master only accepts a new trigger after reset.
- start_req in any other state is ignored; there is no queuing.
- START and STOP in the same sample are impossible. Bus activity outside WAIT_START and WAIT_IDLE is ignored.
- Reset asserted mid-operation aborts immediately to the reset values regardless of state.

Test Plan:
- Nominal power-up (PWRUP_CYC=10, SETTLE_CYC=5, TRIG_CYC=4, IDLE_CYC=8, TIMEOUT_CYC=300, real master attached) -> amp_en rises 10 cycles after reset release; if_resetb and send_cfg rise 5 cycles later; send_cfg is high for exactly 4 cycles; cfg_done and amp_mute=0 follow 8 cycles after the final STOP with bus idle; cfg_err=0.
- Bus held idle after trigger (no START), TIMEOUT_CYC=300 -> ERR exactly 300 cycles after send_cfg rising; cfg_err=1, amp_mute=1, cfg_busy=0.
- Two transactions separated by a 5-cycle idle gap (< IDLE_CYC=8) -> no DONE in the gap; DONE occurs 8 cycles after the second STOP.
- SDA held low forever after START (stuck bus) -> ERR at timeout; cfg_done never asserts.
- start_req pulse in DONE -> next cycle SETTLE: cfg_done=0, amp_mute=1, if_resetb=0; full sequence repeats and re-reaches DONE. A start_req pulse during WAIT_IDLE has no effect.
- resetb pulsed low during WAIT_IDLE -> all outputs return to reset values asynchronously; after release the sequence restarts with amp_en low for PWRUP_CYC cycles.
